fifo_storage_core: RTL and testbench
====================================

FIFO_STORAGE_CORE -- requirements
Module: fifo_storage_core

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, data word width in bits.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (16 by default).
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rest  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_wen_ctrl  input  1  write request from the upstream write-control stage.
REQ-006 SHALL have port i_wdata  input  DATA_WIDTH  write data, sampled with i_wen_ctrl.
REQ-007 SHALL have port i_ren_ctrl  input  1  read request from the downstream consumer.
REQ-008 SHALL have port o_rdata  output  DATA_WIDTH  registered read data.
REQ-009 SHALL have port o_rvalid  output  1  o_rdata holds a newly read word this cycle.
REQ-010 SHALL have port o_full  output  1  occupancy equals DEPTH; fed back to the write-control stage.
REQ-011 SHALL have port o_empty  output  1  occupancy equals 0.
REQ-012 SHALL have port o_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-013 SHALL have port o_ovf_err  output  1  sticky: write request seen while full.
REQ-014 SHALL have port o_udf_err  output  1  sticky: read request seen while empty.
REQ-015 SHALL have ports o_almost_full and o_almost_empty  output  1 each  see Configuration.

Function
REQ-016 SHALL store words in a DEPTH x DATA_WIDTH array that is not reset.
REQ-017 SHALL keep write and read pointers of ADDR_WIDTH+1 bits; low ADDR_WIDTH bits address the array; each pointer wraps naturally from 2*DEPTH-1 to 0.
REQ-018 SHALL decode o_full as pointers differing only in the MSB, o_empty as pointers equal, o_count as (wptr - rptr) modulo 2**(ADDR_WIDTH+1); all three derive only from registered pointers.
REQ-019 SHALL accept a write when i_wen_ctrl=1 and o_full=0: write i_wdata at wptr and increment wptr on that edge.
REQ-020 SHALL accept a read when i_ren_ctrl=1 and o_empty=0: load o_rdata from the array at rptr, increment rptr, and assert o_rvalid for exactly the following cycle (read latency 1).
REQ-021 SHALL drive o_rvalid=0 in any cycle not following an accepted read; o_rdata SHALL hold its last value otherwise.
REQ-022 SHALL, on simultaneous requests when neither full nor empty, accept both; o_count SHALL remain unchanged.
REQ-023 SHALL, on simultaneous requests when full, accept only the read; the write is dropped and o_ovf_err set (no same-cycle write-through).
REQ-024 SHALL, on simultaneous requests when empty, accept only the write; the read is dropped and o_udf_err set (no bypass).
REQ-025 SHALL set o_ovf_err on any i_wen_ctrl=1 while o_full=1 and o_udf_err on any i_ren_ctrl=1 while o_empty=1; both SHALL clear only on reset.
REQ-026 SHALL leave pointers and array contents unchanged by rejected requests.

Reset
REQ-027 SHALL, while i_rest=0, immediately (asynchronously) force wptr=0, rptr=0, o_rdata=0, o_rvalid=0, o_ovf_err=0, o_udf_err=0; hence o_empty=1, o_full=0, o_count=0, o_almost_empty=1 (when enabled), o_almost_full=0.
REQ-028 SHALL discard all stored data on reset mid-operation; the first read after release SHALL be rejected as empty.
REQ-029 SHALL accept no requests on the edge at which i_rest is sampled low.

Configuration
REQ-030 SHALL, when macro FIFO_ALMOST_FLAGS_EN is defined, drive o_almost_full=1 when o_count >= DEPTH-1 and o_almost_empty=1 when o_count <= 1, decoded from registered pointers.
REQ-031 SHALL, when FIFO_ALMOST_FLAGS_EN is not defined, tie o_almost_full and o_almost_empty to constant 0 with no supporting logic; port list unchanged.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4)
REQ-032 SHALL cover: reset released, write 0x01..0x10 on 16 consecutive cycles -> o_full=1, o_count=16 after last edge; 17th write -> dropped, o_ovf_err=1, o_count=16.
REQ-033 SHALL cover: from full, 16 consecutive reads -> o_rvalid=1 one cycle after each, o_rdata 0x01..0x10 in order, then o_empty=1; extra read -> o_udf_err=1, o_rvalid=0.
REQ-034 SHALL cover: 40 interleaved write/read pairs at o_count=5 -> pointers wrap past 31, o_count stays 5, data order preserved.
REQ-035 SHALL cover: simultaneous write 0xAA and read when full -> read returns oldest word, 0xAA not stored, o_count=15; when empty -> 0xAA stored, o_rvalid=0, o_count=1, o_udf_err=1.
REQ-036 SHALL cover: i_rest pulsed low for half a cycle at o_count=9 -> o_count=0, o_empty=1, error flags 0 without waiting for a clock edge.
REQ-037 SHALL cover, with FIFO_ALMOST_FLAGS_EN defined: o_count 14->15 -> o_almost_full rises; o_count 2->1 -> o_almost_empty rises; undefined -> both remain 0 throughout.

Source files
------------

// File: rtl/fifo_storage_core.sv
// ---------------------------------------------------------------------------
// fifo_storage_core
//
// Purpose:
//   Single-clock FIFO storage core. Holds DEPTH = 2**ADDR_WIDTH words of
//   DATA_WIDTH bits in a non-reset array. Pointers are ADDR_WIDTH+1 bits wide
//   so full and empty can be told apart. Reads have one cycle of latency and
//   a registered output. Overflow and underflow attempts set sticky error
//   flags. All status flags are decoded from the registered pointers only.
//
// Optional feature:
//   FIFO_ALMOST_FLAGS_EN - when defined, o_almost_full and o_almost_empty
//   are decoded from the occupancy. When undefined, both ports are tied to 0.
//
// Ports:
//   i_clk          - clock; all state updates on its rising edge
//   i_rest         - asynchronous active-low reset
//   i_wen_ctrl     - write request from the upstream write-control stage
//   i_wdata        - write data, sampled together with i_wen_ctrl
//   i_ren_ctrl     - read request from the downstream consumer
//   o_rdata        - registered read data; holds its value between reads
//   o_rvalid       - o_rdata holds a newly read word this cycle
//   o_full         - occupancy equals DEPTH
//   o_empty        - occupancy equals 0
//   o_count        - current occupancy, 0..DEPTH
//   o_ovf_err      - sticky: write request seen while full
//   o_udf_err      - sticky: read request seen while empty
//   o_almost_full  - occupancy >= DEPTH-1 (only when the feature is enabled)
//   o_almost_empty - occupancy <= 1 (only when the feature is enabled)
// ---------------------------------------------------------------------------
module fifo_storage_core #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rest,
   input  logic                  i_wen_ctrl,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_ren_ctrl,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic                  o_rvalid,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [ADDR_WIDTH:0]   o_count,
   output logic                  o_ovf_err,
   output logic                  o_udf_err,
   output logic                  o_almost_full,
   output logic                  o_almost_empty
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH:0]   r_wptr;
   logic [ADDR_WIDTH:0]   r_rptr;
   logic [DATA_WIDTH-1:0] r_rdata_p1;
   logic                  r_vld_p1;
   logic                  r_ovf_err;
   logic                  r_udf_err;

   logic                  w_full;
   logic                  w_empty;
   logic [ADDR_WIDTH:0]   w_count;
   logic                  w_wr_acc;
   logic                  w_rd_acc;

   // Full: same array slot, opposite lap (MSB differs). Empty: identical.
   assign w_full  = (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]) &&
                    (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]);
   assign w_empty = (r_wptr == r_rptr);
   assign w_count = r_wptr - r_rptr;

   // Accept decisions use the registered flags only, so a write into a full
   // FIFO is dropped even if a read frees a slot on the same edge, and a read
   // from an empty FIFO never bypasses a same-cycle write. The i_rest term
   // keeps the non-reset array from being written on an edge seen in reset.
   assign w_wr_acc = i_rest & i_wen_ctrl & ~w_full;
   assign w_rd_acc = i_ren_ctrl & ~w_empty;

   // Storage array: intentionally not reset.
   always_ff @(posedge i_clk) begin
      if (w_wr_acc) begin
         r_mem[r_wptr[ADDR_WIDTH-1:0]] <= i_wdata;
      end
   end

   // Stage p0 -> p1: pointers, registered read data, valid and sticky errors.
   always_ff @(posedge i_clk or negedge i_rest) begin
      if (!i_rest) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_rdata_p1 <= '0;
         r_vld_p1   <= 1'b0;
         r_ovf_err  <= 1'b0;
         r_udf_err  <= 1'b0;
      end else begin
         r_vld_p1 <= w_rd_acc;
         if (w_wr_acc) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_rd_acc) begin
            r_rptr     <= r_rptr + 1'b1;
            r_rdata_p1 <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
         end
         if (i_wen_ctrl && w_full) begin
            r_ovf_err <= 1'b1;
         end
         if (i_ren_ctrl && w_empty) begin
            r_udf_err <= 1'b1;
         end
      end
   end

   assign o_rdata   = r_rdata_p1;
   assign o_rvalid  = r_vld_p1;
   assign o_full    = w_full;
   assign o_empty   = w_empty;
   assign o_count   = w_count;
   assign o_ovf_err = r_ovf_err;
   assign o_udf_err = r_udf_err;

`ifdef FIFO_ALMOST_FLAGS_EN
   assign o_almost_full  = (w_count >= (ADDR_WIDTH+1)'(DEPTH - 1));
   assign o_almost_empty = (w_count <= (ADDR_WIDTH+1)'(1));
`else
   assign o_almost_full  = 1'b0;
   assign o_almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_storage_core.sv
// ---------------------------------------------------------------------------
// tb_fifo_storage_core
//
// Directed testbench for fifo_storage_core (DATA_WIDTH=8, ADDR_WIDTH=4).
// Inputs are driven 1 ns after the rising edge and outputs are sampled at
// that same point, away from the active edge. Almost-flag expectations follow
// FIFO_ALMOST_FLAGS_EN.
// ---------------------------------------------------------------------------
module tb_fifo_storage_core;

   localparam int DW = 8;
   localparam int AW = 4;

`ifdef FIFO_ALMOST_FLAGS_EN
   localparam bit AF_EN = 1'b1;
`else
   localparam bit AF_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wen;
   logic [DW-1:0] wdata;
   logic          ren;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   logic          ovf;
   logic          udf;
   logic          afull;
   logic          aempty;

   int n_chk = 0;
   int n_err = 0;

   fifo_storage_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .i_clk          (clk),
      .i_rest         (rst_n),
      .i_wen_ctrl     (wen),
      .i_wdata        (wdata),
      .i_ren_ctrl     (ren),
      .o_rdata        (rdata),
      .o_rvalid       (rvalid),
      .o_full         (full),
      .o_empty        (empty),
      .o_count        (count),
      .o_ovf_err      (ovf),
      .o_udf_err      (udf),
      .o_almost_full  (afull),
      .o_almost_empty (aempty)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b1; wen = 1'b0; ren = 1'b0; wdata = '0;
      #1 rst_n = 1'b0;
      #2;
      n_chk++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
      n_chk++; if ({empty, full} !== 2'b10) begin n_err++; $display("FAIL reset_empty_full: got %b expected 10", {empty, full}); end
      n_chk++; if ({rvalid, ovf, udf} !== 3'b000) begin n_err++; $display("FAIL reset_vld_err: got %b expected 000", {rvalid, ovf, udf}); end
      n_chk++; if (rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %0h expected 00", rdata); end
      n_chk++; if ({afull, aempty} !== {1'b0, AF_EN}) begin n_err++; $display("FAIL reset_almost: got %b expected %b", {afull, aempty}, {1'b0, AF_EN}); end
      // Requests while in reset must be ignored.
      wen = 1'b1; wdata = 8'hEE; ren = 1'b1;
      tick;
      tick;
      wen = 1'b0; ren = 1'b0;
      rst_n = 1'b1;
      tick;
      n_chk++; if ({count, empty, ovf, udf} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin n_err++; $display("FAIL reset_no_accept: got cnt=%0d e=%b o=%b u=%b expected cnt=0 e=1 o=0 u=0", count, empty, ovf, udf); end
   endtask

   task automatic test_fill;
      for (int i = 0; i < 16; i++) begin
         wen = 1'b1; wdata = 8'(i + 1);
         tick;
         n_chk++; if (count !== 5'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1); end
         n_chk++; if (afull !== (AF_EN && (i + 1 >= 15))) begin n_err++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, afull, AF_EN && (i + 1 >= 15)); end
      end
      n_chk++; if ({full, empty} !== 2'b10) begin n_err++; $display("FAIL fill_full: got %b expected 10", {full, empty}); end
      n_chk++; if (ovf !== 1'b0) begin n_err++; $display("FAIL fill_ovf_pre: got %b expected 0", ovf); end
      wdata = 8'h55;
      tick;
      wen = 1'b0;
      n_chk++; if ({ovf, full, count} !== {1'b1, 1'b1, 5'd16}) begin n_err++; $display("FAIL fill_17th: got o=%b f=%b cnt=%0d expected o=1 f=1 cnt=16", ovf, full, count); end
   endtask

   task automatic test_drain;
      for (int i = 0; i < 16; i++) begin
         ren = 1'b1;
         tick;
         n_chk++; if ({rvalid, rdata} !== {1'b1, 8'(i + 1)}) begin n_err++; $display("FAIL drain_data[%0d]: got v=%b d=%0h expected v=1 d=%0h", i, rvalid, rdata, i + 1); end
         n_chk++; if (count !== 5'(15 - i)) begin n_err++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, count, 15 - i); end
         n_chk++; if (aempty !== (AF_EN && (15 - i <= 1))) begin n_err++; $display("FAIL drain_aempty[%0d]: got %b expected %b", i, aempty, AF_EN && (15 - i <= 1)); end
      end
      n_chk++; if ({empty, udf} !== 2'b10) begin n_err++; $display("FAIL drain_empty: got %b expected 10", {empty, udf}); end
      tick;
      ren = 1'b0;
      n_chk++; if ({udf, rvalid, rdata} !== {1'b1, 1'b0, 8'h10}) begin n_err++; $display("FAIL drain_extra: got u=%b v=%b d=%0h expected u=1 v=0 d=10", udf, rvalid, rdata); end
      n_chk++; if ({ovf, count} !== {1'b1, 5'd0}) begin n_err++; $display("FAIL drain_sticky: got o=%b cnt=%0d expected o=1 cnt=0", ovf, count); end
   endtask

   task automatic test_wrap;
      for (int i = 0; i < 5; i++) begin
         wen = 1'b1; wdata = 8'(8'h20 + i);
         tick;
      end
      n_chk++; if (count !== 5'd5) begin n_err++; $display("FAIL wrap_pre_count: got %0d expected 5", count); end
      for (int i = 0; i < 40; i++) begin
         wen = 1'b1; ren = 1'b1; wdata = 8'(8'h25 + i);
         tick;
         n_chk++; if ({rvalid, rdata, count} !== {1'b1, 8'(8'h20 + i), 5'd5}) begin n_err++; $display("FAIL wrap_pair[%0d]: got v=%b d=%0h cnt=%0d expected v=1 d=%0h cnt=5", i, rvalid, rdata, count, 8'h20 + i); end
      end
      wen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick;
         n_chk++; if (rdata !== 8'(8'h48 + i)) begin n_err++; $display("FAIL wrap_tail[%0d]: got %0h expected %0h", i, rdata, 8'h48 + i); end
      end
      ren = 1'b0;
      tick;
      n_chk++; if ({rvalid, empty} !== 2'b01) begin n_err++; $display("FAIL wrap_end: got v/e=%b expected 01", {rvalid, empty}); end
   endtask

   task automatic test_async_reset;
      for (int i = 0; i < 9; i++) begin
         wen = 1'b1; wdata = 8'(8'h30 + i);
         tick;
      end
      wen = 1'b0;
      n_chk++; if ({count, ovf, udf} !== {5'd9, 1'b1, 1'b1}) begin n_err++; $display("FAIL arst_pre: got cnt=%0d o=%b u=%b expected cnt=9 o=1 u=1", count, ovf, udf); end
      rst_n = 1'b0;
      #2;
      n_chk++; if ({count, empty, ovf, udf} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin n_err++; $display("FAIL arst_async: got cnt=%0d e=%b o=%b u=%b expected cnt=0 e=1 o=0 u=0", count, empty, ovf, udf); end
      #3 rst_n = 1'b1;
      tick;
   endtask

   task automatic test_simul_empty;
      wen = 1'b1; ren = 1'b1; wdata = 8'hAA;
      tick;
      wen = 1'b0; ren = 1'b0;
      n_chk++; if ({rvalid, count, udf, ovf} !== {1'b0, 5'd1, 1'b1, 1'b0}) begin n_err++; $display("FAIL simul_empty: got v=%b cnt=%0d u=%b o=%b expected v=0 cnt=1 u=1 o=0", rvalid, count, udf, ovf); end
      ren = 1'b1;
      tick;
      ren = 1'b0;
      n_chk++; if ({rvalid, rdata, count} !== {1'b1, 8'hAA, 5'd0}) begin n_err++; $display("FAIL simul_empty_read: got v=%b d=%0h cnt=%0d expected v=1 d=aa cnt=0", rvalid, rdata, count); end
   endtask

   task automatic test_simul_full;
      for (int i = 0; i < 16; i++) begin
         wen = 1'b1; wdata = 8'(8'h60 + i);
         tick;
      end
      n_chk++; if ({full, ovf} !== 2'b10) begin n_err++; $display("FAIL simul_full_pre: got f/o=%b expected 10", {full, ovf}); end
      ren = 1'b1; wdata = 8'hAA;
      tick;
      wen = 1'b0;
      n_chk++; if ({rvalid, rdata, count, ovf} !== {1'b1, 8'h60, 5'd15, 1'b1}) begin n_err++; $display("FAIL simul_full: got v=%b d=%0h cnt=%0d o=%b expected v=1 d=60 cnt=15 o=1", rvalid, rdata, count, ovf); end
      for (int i = 1; i < 16; i++) begin
         tick;
         n_chk++; if (rdata !== 8'(8'h60 + i)) begin n_err++; $display("FAIL simul_full_drain[%0d]: got %0h expected %0h", i, rdata, 8'h60 + i); end
      end
      ren = 1'b0;
      n_chk++; if ({count, empty} !== {5'd0, 1'b1}) begin n_err++; $display("FAIL simul_full_end: got cnt=%0d e=%b expected cnt=0 e=1", count, empty); end
   endtask

   initial begin
      test_reset;
      test_fill;
      test_drain;
      test_wrap;
      test_async_reset;
      test_simul_empty;
      test_simul_full;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
